// File: rtl/id_ex_pipe_stage.sv
// Elastic ID/EX pipeline register with valid/ready handshake, flush and stall counter.
// Define ID_EX_SKID_EN to add a one-entry skid buffer that registers in_ready.
module id_ex_pipe_stage #(
   parameter int unsigned DATA_WIDTH      = 64,
   parameter int unsigned REG_ID_WIDTH    = 5,
   parameter int unsigned ALU_OP_WIDTH    = 7,
   parameter int unsigned ALU_FUNC3_WIDTH = 3,
   parameter int unsigned ALU_FUNC7_WIDTH = 7,
   parameter int unsigned EX_CTRL_WIDTH   = 1 + ALU_OP_WIDTH + ALU_FUNC3_WIDTH + ALU_FUNC7_WIDTH,
   parameter int unsigned CNT_WIDTH       = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DATA_WIDTH-1:0]    pc_in,
   input  logic [DATA_WIDTH-1:0]    data1_in,
   input  logic [DATA_WIDTH-1:0]    data2_in,
   input  logic [DATA_WIDTH-1:0]    imm_in,
   input  logic [REG_ID_WIDTH-1:0]  dest_in,
   input  logic [REG_ID_WIDTH-1:0]  reg1_in,
   input  logic [REG_ID_WIDTH-1:0]  reg2_in,
   input  logic [EX_CTRL_WIDTH-1:0] ex_control_in,
   input  logic [1:0]               mem_control_in,
   input  logic [1:0]               wb_control_in,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     flush,
   output logic [DATA_WIDTH-1:0]    pc_out,
   output logic [DATA_WIDTH-1:0]    data1_out,
   output logic [DATA_WIDTH-1:0]    data2_out,
   output logic [DATA_WIDTH-1:0]    imm_out,
   output logic [REG_ID_WIDTH-1:0]  dest_out,
   output logic [REG_ID_WIDTH-1:0]  reg1_out,
   output logic [REG_ID_WIDTH-1:0]  reg2_out,
   output logic [EX_CTRL_WIDTH-1:0] ex_control_out,
   output logic [1:0]               mem_control_out,
   output logic [1:0]               wb_control_out,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CNT_WIDTH-1:0]     stall_count
);

   localparam int unsigned PayW = 4 * DATA_WIDTH + 3 * REG_ID_WIDTH + EX_CTRL_WIDTH + 4;

   logic [PayW-1:0]      pay_in;
   logic [PayW-1:0]      main_d, main_q;
   logic                 out_valid_d, out_valid_q;
   logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
   logic [1:0]           mem_raw, wb_raw;
   logic                 in_fire, out_fire;

   assign pay_in = {pc_in, data1_in, data2_in, imm_in, dest_in, reg1_in, reg2_in,
                    ex_control_in, mem_control_in, wb_control_in};

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid_q & out_ready;

`ifdef ID_EX_SKID_EN
   logic [PayW-1:0] skid_d, skid_q;
   logic            skid_valid_d, skid_valid_q;

   // Ready comes straight from a flop, so no combinational path from out_ready.
   assign in_ready = ~skid_valid_q;

   always_comb begin
      main_d       = main_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (out_fire) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
         end else if (in_fire) begin
            main_d = pay_in;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (in_fire) begin
         if (out_valid_q) begin
            skid_d       = pay_in;
            skid_valid_d = 1'b1;
         end else begin
            main_d      = pay_in;
            out_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
      end
   end
`else
   assign in_ready = ~out_valid_q | out_ready;

   always_comb begin
      main_d      = main_q;
      out_valid_d = out_valid_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (in_fire) begin
         main_d      = pay_in;
         out_valid_d = 1'b1;
      end else if (out_fire) begin
         out_valid_d = 1'b0;
      end
   end
`endif

   always_comb begin
      cnt_d = cnt_q;
      if (out_valid_q && !out_ready && !flush && (cnt_q != {CNT_WIDTH{1'b1}})) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         main_q      <= '0;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         main_q      <= main_d;
         out_valid_q <= out_valid_d;
         cnt_q       <= cnt_d;
      end
   end

   assign {pc_out, data1_out, data2_out, imm_out, dest_out, reg1_out, reg2_out,
           ex_control_out, mem_raw, wb_raw} = main_q;

   // Bubbles must never write memory or the register file.
   assign mem_control_out = out_valid_q ? mem_raw : 2'b00;
   assign wb_control_out  = out_valid_q ? wb_raw : 2'b00;
   assign out_valid       = out_valid_q;
   assign stall_count     = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Randomised bench for id_ex_pipe_stage; reference model is a bounded FIFO of instructions.
module tb_id_ex_pipe_stage;

   typedef struct packed {
      logic [63:0] pc;
      logic [63:0] d1;
      logic [63:0] d2;
      logic [63:0] imm;
      logic [4:0]  dest;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [17:0] ex;
      logic [1:0]  mem;
      logic [1:0]  wb;
   } pay_t;

   logic        clk, reset, in_valid, in_ready, flush, out_valid, out_ready;
   pay_t        in_p, out_p;
   logic [63:0] pc_out, data1_out, data2_out, imm_out;
   logic [4:0]  dest_out, reg1_out, reg2_out;
   logic [17:0] ex_control_out;
   logic [1:0]  mem_control_out, wb_control_out;
   logic [15:0] stall_count;

   logic        s_in_ready, s_out_valid;
   logic [63:0] s_pc, s_d1, s_d2, s_imm;
   logic [4:0]  s_dest, s_r1, s_r2;
   logic [17:0] s_ex;
   logic [1:0]  s_mem, s_wb;
   logic [1:0]  s_stall_count;

   int   n_tests = 0;
   int   n_fail  = 0;
   pay_t q[$];
   int   m_cnt;
   int   m_cnt2;

   id_ex_pipe_stage dut (
      .clk(clk), .reset(reset),
      .pc_in(in_p.pc), .data1_in(in_p.d1), .data2_in(in_p.d2), .imm_in(in_p.imm),
      .dest_in(in_p.dest), .reg1_in(in_p.r1), .reg2_in(in_p.r2),
      .ex_control_in(in_p.ex), .mem_control_in(in_p.mem), .wb_control_in(in_p.wb),
      .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .pc_out(pc_out), .data1_out(data1_out), .data2_out(data2_out), .imm_out(imm_out),
      .dest_out(dest_out), .reg1_out(reg1_out), .reg2_out(reg2_out),
      .ex_control_out(ex_control_out), .mem_control_out(mem_control_out),
      .wb_control_out(wb_control_out), .out_valid(out_valid), .out_ready(out_ready),
      .stall_count(stall_count)
   );

   id_ex_pipe_stage #(.CNT_WIDTH(2)) dut_sat (
      .clk(clk), .reset(reset),
      .pc_in(in_p.pc), .data1_in(in_p.d1), .data2_in(in_p.d2), .imm_in(in_p.imm),
      .dest_in(in_p.dest), .reg1_in(in_p.r1), .reg2_in(in_p.r2),
      .ex_control_in(in_p.ex), .mem_control_in(in_p.mem), .wb_control_in(in_p.wb),
      .in_valid(in_valid), .in_ready(s_in_ready), .flush(flush),
      .pc_out(s_pc), .data1_out(s_d1), .data2_out(s_d2), .imm_out(s_imm),
      .dest_out(s_dest), .reg1_out(s_r1), .reg2_out(s_r2),
      .ex_control_out(s_ex), .mem_control_out(s_mem),
      .wb_control_out(s_wb), .out_valid(s_out_valid), .out_ready(out_ready),
      .stall_count(s_stall_count)
   );

   assign out_p = {pc_out, data1_out, data2_out, imm_out, dest_out, reg1_out, reg2_out,
                   ex_control_out, mem_control_out, wb_control_out};

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [319:0] act, input logic [319:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic pay_t rand_pay();
      logic [319:0] v;
      for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom();
      return v[$bits(pay_t)-1:0];
   endfunction

   function automatic logic model_ready(input logic ordy);
`ifdef ID_EX_SKID_EN
      return q.size() < 2;
`else
      return (q.size() == 0) || ordy;
`endif
   endfunction

   // One clock: drive, compare against the model, clock, advance the model.
   task automatic step(input logic iv, input pay_t ip, input logic ordy, input logic fl,
                       input logic rst);
      logic exp_ready;
      @(negedge clk);
      in_valid = iv; in_p = ip; out_ready = ordy; flush = fl; reset = rst;
      #1;
      exp_ready = model_ready(ordy);
      check_eq("in_ready", in_ready, exp_ready);
      check_eq("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) check_eq("payload", out_p, q[0]);
      else check_eq("bubble_ctl", {mem_control_out, wb_control_out}, 4'h0);
      check_eq("stall_count", stall_count, m_cnt);
      check_eq("stall_sat", s_stall_count, m_cnt2);
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_cnt  = 0;
         m_cnt2 = 0;
      end else begin
         if (q.size() > 0 && !ordy && !fl) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
         end
         if (fl) begin
            q.delete();
         end else begin
            logic ofire, ifire;
            ofire = (q.size() > 0) && ordy;
            ifire = iv && exp_ready;
            if (ofire) void'(q.pop_front());
            if (ifire) q.push_back(ip);
         end
      end
      #1;
   endtask

   pay_t p;

   initial begin
      clk = 0; reset = 1; in_valid = 0; out_ready = 0; flush = 0; in_p = '0;
      m_cnt = 0; m_cnt2 = 0;
      repeat (2) @(posedge clk);
      #1;

      // Single instruction, 1-cycle latency.
      p = '0; p.pc = 64'h1000; p.wb = 2'b10;
      step(1, p, 1, 0, 0);
      check_eq("t1_valid", out_valid, 1'b1);
      check_eq("t1_pc", pc_out, 64'h1000);
      check_eq("t1_wb", wb_control_out, 2'b10);
      check_eq("t1_cnt", stall_count, 16'd0);

      // Back-to-back stream at full throughput.
      for (int i = 0; i < 3; i++) begin
         p = rand_pay(); p.pc = 64'(i * 4);
         step(1, p, 1, 0, 0);
         check_eq("t2_pc", pc_out, 64'(i * 4));
         check_eq("t2_ready", in_ready, 1'b1);
      end
      step(0, '0, 1, 0, 0);

      // Stall hold and saturating counter.
      step(0, '0, 1, 0, 1);
      p = rand_pay(); p.pc = 64'h20;
      step(1, p, 0, 0, 0);
      repeat (5) step(0, rand_pay(), 0, 0, 0);
      check_eq("t3_pc", pc_out, 64'h20);
      check_eq("t3_cnt", stall_count, 16'd5);
      check_eq("t3_sat", s_stall_count, 2'd3);
      step(0, '0, 1, 0, 0);

      // Flush kills held instruction and the same-cycle input.
      p = rand_pay(); p.mem = 2'b01;
      step(1, p, 0, 0, 0);
      p = rand_pay(); p.pc = 64'h40;
      step(1, p, 0, 1, 0);
      check_eq("t4_valid", out_valid, 1'b0);
      check_eq("t4_mem", mem_control_out, 2'b00);
      repeat (2) step(0, '0, 1, 0, 0);
      check_eq("t4_gone", out_valid, 1'b0);

      // Two sends under back-pressure, then drain in order.
      step(0, '0, 1, 0, 1);
      p = rand_pay(); p.pc = 64'hA0; step(1, p, 0, 0, 0);
      p = rand_pay(); p.pc = 64'hA4; step(1, p, 0, 0, 0);
      step(0, '0, 0, 0, 0);
      repeat (3) step(0, '0, 1, 0, 0);

      // Reset while holding (and, with skid, full).
      p = rand_pay(); step(1, p, 0, 0, 0);
      p = rand_pay(); step(1, p, 0, 0, 0);
      step(1, rand_pay(), 0, 0, 1);
      check_eq("t6_valid", out_valid, 1'b0);
      check_eq("t6_zero", out_p, '0);
      check_eq("t6_cnt", stall_count, 16'd0);
      check_eq("t6_sat", s_stall_count, 2'd0);

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) != 0, rand_pay(), $urandom_range(0, 9) < 6,
              $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
